// File: rtl/mod_type_detect_pkg.sv
// Shared encodings for the modulation-type detector: reported signal types,
// FSM states and the width of the hysteresis agree counter.
package mod_type_detect_pkg;

  typedef enum logic [1:0] {
    TYPE_NONE = 2'd0,
    TYPE_AM   = 2'd1,
    TYPE_ASK  = 2'd2
  } sig_type_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACC    = 2'd1,
    ST_DECIDE = 2'd2
  } state_t;

  localparam int AGREE_W = 4;

endpackage

// File: rtl/mod_type_detect_if.sv
// Sample/threshold inputs and classification results of mod_type_detect.
interface mod_type_detect_if
  import mod_type_detect_pkg::*;
#(
  parameter int DW = 10,
  parameter int CW = 16
);
  logic            en;
  logic [DW-1:0]   ad_data;
  logic [CW-1:0]   win_len;
  logic [DW-1:0]   low_thr;
  logic [CW-1:0]   ask_thr;
  logic [DW-1:0]   sig_thr;
  sig_type_t       sig_type;
  logic            type_valid;
  logic            am_en;
  logic            ask_en;
  logic            win_done;
  logic [DW-1:0]   win_max;
  logic [DW-1:0]   win_min;
  logic [CW-1:0]   win_low_cnt;

  modport master (
    output en, ad_data, win_len, low_thr, ask_thr, sig_thr,
    input  sig_type, type_valid, am_en, ask_en, win_done, win_max, win_min, win_low_cnt
  );

  modport slave (
    input  en, ad_data, win_len, low_thr, ask_thr, sig_thr,
    output sig_type, type_valid, am_en, ask_en, win_done, win_max, win_min, win_low_cnt
  );
endinterface

// File: rtl/mod_type_detect_win_stats.sv
// Per-window accumulator: running max/min and a saturating low-level point count.
module mod_type_detect_win_stats #(
  parameter int DW = 10,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          update,
  input  logic [DW-1:0] sample,
  input  logic [DW-1:0] low_thr,
  output logic [DW-1:0] run_max,
  output logic [DW-1:0] run_min,
  output logic [CW-1:0] run_low
);
  logic [DW-1:0] max_reg;
  logic [DW-1:0] min_reg;
  logic [CW-1:0] low_reg;
  logic          is_low;

  assign is_low = (sample < low_thr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_reg <= '0;
      min_reg <= '0;
      low_reg <= '0;
    end else if (load) begin
      max_reg <= sample;
      min_reg <= sample;
      low_reg <= CW'(is_low);
    end else if (update) begin
      if (sample > max_reg) max_reg <= sample;
      if (sample < min_reg) min_reg <= sample;
      if (is_low && (low_reg != '1)) low_reg <= low_reg + CW'(1);
    end
  end

  assign run_max = max_reg;
  assign run_min = min_reg;
  assign run_low = low_reg;

endmodule

// File: rtl/mod_type_detect.sv
// Windowed AM/ASK/NONE classifier with a consecutive-agreement hysteresis
// on the reported type.
module mod_type_detect
  import mod_type_detect_pkg::*;
#(
  parameter int DW      = 10,
  parameter int CW      = 16,
  parameter int CONFIRM = 3
) (
  input  logic            clk,
  input  logic            rst,
  mod_type_detect_if.slave bus
);
  localparam logic [AGREE_W-1:0] CONFIRM_CNT = AGREE_W'(CONFIRM);
  localparam logic [CW-1:0]      MIN_LEN     = CW'(2);

  state_t              state_reg;
  logic [CW-1:0]       eff_len_reg;
  logic [CW-1:0]       cnt_reg;
  sig_type_t           type_reg;
  sig_type_t           cand_reg;
  logic [AGREE_W-1:0]  agree_reg;
  logic                valid_reg;
  logic                am_reg;
  logic                ask_reg;
  logic                done_reg;
  logic [DW-1:0]       win_max_reg;
  logic [DW-1:0]       win_min_reg;
  logic [CW-1:0]       win_low_reg;

  logic [DW-1:0]       run_max;
  logic [DW-1:0]       run_min;
  logic [CW-1:0]       run_low;
  logic                load;
  logic                update;
  logic [CW-1:0]       cnt_inc;
  logic [CW-1:0]       eff_len;
  logic [DW-1:0]       peak;
  sig_type_t           cls;
  logic [AGREE_W-1:0]  agree_inc;
  sig_type_t           type_next;
  sig_type_t           cand_next;
  logic [AGREE_W-1:0]  agree_next;
  logic                valid_next;

  // A window that follows DECIDE starts with cnt_reg==0, so its first ACC
  // clock loads the accumulator instead of merging into the previous window.
  assign load    = bus.en && ((state_reg == ST_IDLE) || (state_reg == ST_ACC && cnt_reg == '0));
  assign update  = bus.en && (state_reg == ST_ACC) && (cnt_reg != '0);
  assign cnt_inc = cnt_reg + CW'(1);
  assign eff_len = (bus.win_len < MIN_LEN) ? MIN_LEN : bus.win_len;
  assign peak    = run_max - run_min;

  mod_type_detect_win_stats #(.DW(DW), .CW(CW)) u_win_stats (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .update  (update),
    .sample  (bus.ad_data),
    .low_thr (bus.low_thr),
    .run_max (run_max),
    .run_min (run_min),
    .run_low (run_low)
  );

  always_comb begin
    cls = TYPE_AM;
    if (peak < bus.sig_thr)
      cls = TYPE_NONE;
    else if (run_low > bus.ask_thr)
      cls = TYPE_ASK;
  end

  assign agree_inc = ((cls == cand_reg) && (agree_reg != '0)) ? agree_reg + AGREE_W'(1)
                                                              : AGREE_W'(1);

  // Until the first confirmation every classification, NONE included, is a candidate.
  always_comb begin
    type_next  = type_reg;
    cand_next  = cand_reg;
    agree_next = agree_reg;
    valid_next = valid_reg;
    if (valid_reg && (cls == type_reg)) begin
      agree_next = '0;
    end else begin
      cand_next = cls;
      if (agree_inc == CONFIRM_CNT) begin
        type_next  = cls;
        agree_next = '0;
        valid_next = 1'b1;
      end else begin
        agree_next = agree_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      eff_len_reg <= '0;
      cnt_reg     <= '0;
      type_reg    <= TYPE_NONE;
      cand_reg    <= TYPE_NONE;
      agree_reg   <= '0;
      valid_reg   <= 1'b0;
      am_reg      <= 1'b0;
      ask_reg     <= 1'b0;
      done_reg    <= 1'b0;
      win_max_reg <= '0;
      win_min_reg <= '0;
      win_low_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          type_reg  <= TYPE_NONE;
          cand_reg  <= TYPE_NONE;
          agree_reg <= '0;
          valid_reg <= 1'b0;
          am_reg    <= 1'b0;
          ask_reg   <= 1'b0;
          if (bus.en) begin
            state_reg   <= ST_ACC;
            eff_len_reg <= eff_len;
            cnt_reg     <= CW'(1);
          end
        end
        ST_ACC: begin
          if (!bus.en) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            type_reg  <= TYPE_NONE;
            cand_reg  <= TYPE_NONE;
            agree_reg <= '0;
            valid_reg <= 1'b0;
            am_reg    <= 1'b0;
            ask_reg   <= 1'b0;
          end else begin
            cnt_reg <= cnt_inc;
            if (cnt_inc == eff_len_reg) state_reg <= ST_DECIDE;
          end
        end
        ST_DECIDE: begin
          win_max_reg <= run_max;
          win_min_reg <= run_min;
          win_low_reg <= run_low;
          done_reg    <= 1'b1;
          type_reg    <= type_next;
          cand_reg    <= cand_next;
          agree_reg   <= agree_next;
          valid_reg   <= valid_next;
          am_reg      <= valid_next && (type_next == TYPE_AM);
          ask_reg     <= valid_next && (type_next == TYPE_ASK);
          cnt_reg     <= '0;
          if (bus.en) begin
            state_reg   <= ST_ACC;
            eff_len_reg <= eff_len;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.sig_type    = type_reg;
  assign bus.type_valid  = valid_reg;
  assign bus.am_en       = am_reg;
  assign bus.ask_en      = ask_reg;
  assign bus.win_done    = done_reg;
  assign bus.win_max     = win_max_reg;
  assign bus.win_min     = win_min_reg;
  assign bus.win_low_cnt = win_low_reg;

endmodule
